// File: rtl/microwave_pkg.sv
// microwave_pkg: shared state encoding, digit width and debounce default
// for the keypad countdown timer.
package microwave_pkg;
    typedef enum logic [1:0] {IDLE, ENTRY, COUNTING, PAUSED} state_t;
    localparam int BCD_W            = 4;
    localparam int DEBOUNCE_DEFAULT = 4;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: accepts one key per press once loadn has been low with a
// stable code for DEBOUNCE_CYCLES cycles; releasing loadn re-arms.
module key_debounce
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clock,
    input  logic             clearn,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             loadn,
    output logic             accept,
    output logic [BCD_W-1:0] digit
);
    localparam logic [4:0] LIM = 5'(DEBOUNCE_CYCLES);
    logic [3:0]       cnt;
    logic [BCD_W-1:0] last;
    logic             armed;
    logic             same;
    logic [4:0]       nxt;
    logic             hit;
    always_comb begin
        same = (cnt != 4'd0) && (bcd_in == last);
        nxt  = same ? {1'b0, cnt} + 5'd1 : 5'd1;
        hit  = !loadn && armed && (nxt == LIM);
    end
    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            cnt    <= 4'd0;
            last   <= '0;
            armed  <= 1'b1;
            accept <= 1'b0;
            digit  <= '0;
        end else begin
            accept <= hit;
            if (hit) digit <= bcd_in;
            if (loadn) begin
                cnt   <= 4'd0;
                armed <= 1'b1;
            end else begin
                // saturate so a held key never wraps into a second accept
                cnt  <= (nxt > LIM) ? LIM[3:0] : nxt[3:0];
                last <= bcd_in;
                if (nxt == LIM) armed <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/keypad_timer.sv
// keypad_timer: mm:ss BCD countdown with keypad entry, start/pause/clear
// buttons and a one-cycle done pulse; all outputs registered.
module keypad_timer
    import microwave_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clock,
    input  logic             clearn,
    input  logic [BCD_W-1:0] BCD_IN,
    input  logic             loadn,
    input  logic             startn,
    input  logic             stopn,
    input  logic             tick_1hz,
    output logic [BCD_W-1:0] sec_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] min_tens,
    output logic             enablen,
    output logic             counting,
    output logic             done
);
    state_t           state, state_n;
    logic             start_d, stop_d, start_e, stop_e;
    logic             accept;
    logic [BCD_W-1:0] digit;
    logic [BCD_W-1:0] so_n, st_n, mo_n, mt_n;
    logic [BCD_W-1:0] ds_o, ds_t, dm_o, dm_t;
    logic             b1, b2, b3, zero, done_n;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clock  (clock),
        .clearn (clearn),
        .bcd_in (BCD_IN),
        .loadn  (loadn),
        .accept (accept),
        .digit  (digit)
    );

    always_comb begin
        start_e = start_d && !startn;
        stop_e  = stop_d && !stopn;
        zero    = {min_tens, min_ones, sec_tens, sec_ones} == 16'h0000;
        b1      = sec_ones == 4'd0;
        b2      = b1 && sec_tens == 4'd0;
        b3      = b2 && min_ones == 4'd0;
        ds_o    = b1 ? 4'd9 : sec_ones - 4'd1;
        ds_t    = b1 ? (sec_tens == 4'd0 ? 4'd5 : sec_tens - 4'd1) : sec_tens;
        dm_o    = b2 ? (min_ones == 4'd0 ? 4'd9 : min_ones - 4'd1) : min_ones;
        dm_t    = b3 ? min_tens - 4'd1 : min_tens;
        state_n = state;
        {mt_n, mo_n, st_n, so_n} = {min_tens, min_ones, sec_tens, sec_ones};
        done_n  = 1'b0;
        // priority: stop, start, tick, key; any button edge drops a coincident key
        if (stop_e) begin
            if (state == COUNTING) state_n = PAUSED;
            else if (state != IDLE) begin
                state_n = IDLE;
                {mt_n, mo_n, st_n, so_n} = 16'h0000;
            end
        end else if (start_e) begin
            if ((state == ENTRY && !zero) || state == PAUSED) state_n = COUNTING;
        end else if (tick_1hz && state == COUNTING) begin
            {mt_n, mo_n, st_n, so_n} = {dm_t, dm_o, ds_t, ds_o};
            if ({dm_t, dm_o, ds_t, ds_o} == 16'h0000) begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else if (accept && digit <= 4'd9 && (state == IDLE || state == ENTRY)) begin
            {mt_n, mo_n, st_n, so_n} = {min_ones, sec_tens, sec_ones, digit};
            state_n = ENTRY;
        end
    end

    always_ff @(posedge clock or negedge clearn) begin
        if (!clearn) begin
            state    <= IDLE;
            {min_tens, min_ones, sec_tens, sec_ones} <= 16'h0000;
            enablen  <= 1'b0;
            counting <= 1'b0;
            done     <= 1'b0;
            start_d  <= 1'b1;
            stop_d   <= 1'b1;
        end else begin
            state    <= state_n;
            {min_tens, min_ones, sec_tens, sec_ones} <= {mt_n, mo_n, st_n, so_n};
            enablen  <= state_n == COUNTING || state_n == PAUSED;
            counting <= state_n == COUNTING;
            done     <= done_n;
            start_d  <= startn;
            stop_d   <= stopn;
        end
    end
endmodule

// File: tb/tb_keypad_timer.sv
// tb_keypad_timer: directed scenarios plus randomized operations checked
// against a decimal-value model of the timer.
module tb_keypad_timer;
    localparam int D = 4;
    localparam int M_IDLE = 0, M_ENTRY = 1, M_COUNT = 2, M_PAUSE = 3;

    logic       clock = 1'b0, clearn = 1'b0, loadn = 1'b1, startn = 1'b1, stopn = 1'b1, tick_1hz = 1'b0;
    logic [3:0] BCD_IN = 4'd0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       enablen, counting, done;
    logic [17:0] obs;
    int checks = 0, errors = 0;
    int mv = 0, ms = M_IDLE;

    assign obs = {enablen, counting, min_tens, min_ones, sec_tens, sec_ones};

    keypad_timer #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .clearn(clearn), .BCD_IN(BCD_IN), .loadn(loadn),
        .startn(startn), .stopn(stopn), .tick_1hz(tick_1hz),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .min_ones(min_ones), .min_tens(min_tens),
        .enablen(enablen), .counting(counting), .done(done)
    );

    always #5 clock = ~clock;

    // model: displayed value as a 4-digit decimal number mmss
    function automatic logic [17:0] model_obs();
        logic e;
        e = (ms == M_COUNT) || (ms == M_PAUSE);
        return {e, ms == M_COUNT, 4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
    endfunction

    task automatic m_key(input int d, input int hold);
        if (hold >= D && d <= 9 && (ms == M_IDLE || ms == M_ENTRY)) begin
            mv = (mv % 1000) * 10 + d;
            ms = M_ENTRY;
        end
    endtask

    task automatic m_start();
        if ((ms == M_ENTRY && mv != 0) || ms == M_PAUSE) ms = M_COUNT;
    endtask

    task automatic m_stop();
        if (ms == M_COUNT) ms = M_PAUSE;
        else if (ms != M_IDLE) begin
            ms = M_IDLE;
            mv = 0;
        end
    endtask

    task automatic m_tick(output logic dn);
        int m, s;
        dn = 1'b0;
        if (ms == M_COUNT) begin
            m = mv / 100;
            s = mv % 100;
            if (s > 0) s--;
            else begin
                m--;
                s = 59;
            end
            mv = m * 100 + s;
            if (mv == 0) begin
                ms = M_IDLE;
                dn = 1'b1;
            end
        end
    endtask

    task automatic press(input logic [3:0] d, input int hold);
        loadn = 1'b0;
        BCD_IN = d;
        repeat (hold) @(negedge clock);
        loadn = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic pulse_start();
        startn = 1'b0;
        @(negedge clock);
        startn = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulse_stop();
        stopn = 1'b0;
        @(negedge clock);
        stopn = 1'b1;
        @(negedge clock);
    endtask

    task automatic pulse_both();
        startn = 1'b0;
        stopn = 1'b0;
        @(negedge clock);
        startn = 1'b1;
        stopn = 1'b1;
        @(negedge clock);
    endtask

    task automatic do_tick(output logic dn);
        tick_1hz = 1'b1;
        @(negedge clock);
        tick_1hz = 1'b0;
        dn = done;
    endtask

    task automatic test_reset();
        clearn = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL reset_outputs: got %h expected %h", obs, 18'h0); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        clearn = 1'b1;
        @(negedge clock);
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL after_reset: got %h expected %h", obs, 18'h0); end
    endtask

    task automatic test_entry();
        press(4'd1, 6);
        checks++;
        if (obs !== {2'b00, 16'h0001}) begin errors++; $display("FAIL entry_first: got %h expected %h", obs, {2'b00, 16'h0001}); end
        press(4'd3, 6);
        press(4'd0, 6);
        checks++;
        if (obs !== {2'b00, 16'h0130}) begin errors++; $display("FAIL entry_0130: got %h expected %h", obs, {2'b00, 16'h0130}); end
        pulse_stop();
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL entry_stop_clear: got %h expected %h", obs, 18'h0); end
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 5; i++) press(4'(i), 5);
        checks++;
        if (obs !== {2'b00, 16'h2345}) begin errors++; $display("FAIL wrap_2345: got %h expected %h", obs, {2'b00, 16'h2345}); end
        press(4'd12, 6);
        checks++;
        if (obs !== {2'b00, 16'h2345}) begin errors++; $display("FAIL invalid_digit: got %h expected %h", obs, {2'b00, 16'h2345}); end
        pulse_stop();
    endtask

    task automatic test_countdown();
        logic dn;
        int early;
        press(4'd1, 5);
        press(4'd0, 5);
        press(4'd0, 5);
        pulse_start();
        checks++;
        if (obs !== {2'b11, 16'h0100}) begin errors++; $display("FAIL start_count: got %h expected %h", obs, {2'b11, 16'h0100}); end
        do_tick(dn);
        do_tick(dn);
        checks++;
        if (obs !== {2'b11, 16'h0058}) begin errors++; $display("FAIL two_ticks: got %h expected %h", obs, {2'b11, 16'h0058}); end
        pulse_stop();
        do_tick(dn);
        checks++;
        if (obs !== {2'b10, 16'h0058}) begin errors++; $display("FAIL paused_hold: got %h expected %h", obs, {2'b10, 16'h0058}); end
        pulse_start();
        checks++;
        if (obs !== {2'b11, 16'h0058}) begin errors++; $display("FAIL resume: got %h expected %h", obs, {2'b11, 16'h0058}); end
        early = 0;
        for (int i = 0; i < 57; i++) begin
            do_tick(dn);
            if (dn) early++;
        end
        checks++;
        if (early != 0) begin errors++; $display("FAIL early_done: got %0d pulses expected 0", early); end
        do_tick(dn);
        checks++;
        if (dn !== 1'b1 || obs !== 18'h0) begin errors++; $display("FAIL reach_zero: got done=%b obs=%h expected done=1 obs=%h", dn, obs, 18'h0); end
        @(negedge clock);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_debounce();
        press(4'd7, 3);
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL short_press: got %h expected %h", obs, 18'h0); end
        loadn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            BCD_IN = (i % 2 == 0) ? 4'd6 : 4'd5;
            @(negedge clock);
        end
        loadn = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL toggling_press: got %h expected %h", obs, 18'h0); end
        press(4'd7, 50);
        checks++;
        if (obs !== {2'b00, 16'h0007}) begin errors++; $display("FAIL held_press: got %h expected %h", obs, {2'b00, 16'h0007}); end
    endtask

    task automatic test_simultaneous();
        logic dn;
        pulse_both();
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL stop_beats_start: got %h expected %h", obs, 18'h0); end
        pulse_start();
        press(4'd0, 5);
        pulse_start();
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL start_at_zero: got %h expected %h", obs, 18'h0); end
        press(4'd4, 5);
        loadn = 1'b0;
        BCD_IN = 4'd8;
        repeat (D) @(negedge clock);
        startn = 1'b0;
        @(negedge clock);
        startn = 1'b1;
        loadn = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== {2'b11, 16'h0004}) begin errors++; $display("FAIL start_beats_key: got %h expected %h", obs, {2'b11, 16'h0004}); end
        stopn = 1'b0;
        tick_1hz = 1'b1;
        @(negedge clock);
        stopn = 1'b1;
        tick_1hz = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== {2'b10, 16'h0004}) begin errors++; $display("FAIL stop_beats_tick: got %h expected %h", obs, {2'b10, 16'h0004}); end
        pulse_stop();
        do_tick(dn);
        checks++;
        if (obs !== 18'h0 || dn !== 1'b0) begin errors++; $display("FAIL idle_tick: got obs=%h done=%b expected %h done=0", obs, dn, 18'h0); end
    endtask

    task automatic test_clear();
        logic dn;
        press(4'd5, 5);
        press(4'd1, 5);
        press(4'd7, 5);
        pulse_start();
        checks++;
        if (obs !== {2'b11, 16'h0517}) begin errors++; $display("FAIL count_0517: got %h expected %h", obs, {2'b11, 16'h0517}); end
        #2 clearn = 1'b0;
        #1;
        checks++;
        if (obs !== 18'h0 || done !== 1'b0) begin errors++; $display("FAIL async_clear: got obs=%h done=%b expected %h done=0", obs, done, 18'h0); end
        @(negedge clock);
        clearn = 1'b1;
        repeat (3) do_tick(dn);
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL ticks_after_clear: got %h expected %h", obs, 18'h0); end
        loadn = 1'b0;
        BCD_IN = 4'd3;
        repeat (3) @(negedge clock);
        clearn = 1'b0;
        @(negedge clock);
        clearn = 1'b1;
        repeat (3) @(negedge clock);
        loadn = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (obs !== 18'h0) begin errors++; $display("FAIL debounce_cleared: got %h expected %h", obs, 18'h0); end
    endtask

    task automatic test_random();
        logic dn, mdn;
        int op, d, hold, n;
        clearn = 1'b0;
        @(negedge clock);
        clearn = 1'b1;
        @(negedge clock);
        mv = 0;
        ms = M_IDLE;
        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                d = $urandom_range(0, 12);
                hold = $urandom_range(1, 7);
                press(4'(d), hold);
                m_key(d, hold);
            end else if (op == 4) begin
                pulse_start();
                m_start();
            end else if (op == 5) begin
                pulse_stop();
                m_stop();
            end else if (op == 9) begin
                pulse_both();
                m_stop();
            end else begin
                n = $urandom_range(1, 20);
                for (int k = 0; k < n; k++) begin
                    do_tick(dn);
                    m_tick(mdn);
                    checks++;
                    if (dn !== mdn) begin errors++; $display("FAIL rand_done it=%0d: got %b expected %b", it, dn, mdn); end
                end
            end
            checks++;
            if (obs !== model_obs()) begin errors++; $display("FAIL rand_state it=%0d op=%0d: got %h expected %h", it, op, obs, model_obs()); end
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_wrap();
        test_countdown();
        test_debounce();
        test_simultaneous();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_timer.md
KEYPAD_TIMER -- requirements
Module: keypad_timer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive clock cycles loadn must stay low with a stable BCD_IN before a key is accepted (legal range 1..15).
REQ-002 clock  in  1  sole clock; all state SHALL change on its rising edge.
REQ-003 clearn  in  1  reset, asynchronous, active-low.
REQ-004 BCD_IN  in  4  digit code from the keypad priority encoder.
REQ-005 loadn  in  1  active-low key-valid from the encoder.
REQ-006 startn  in  1  active-low start button, synchronous.
REQ-007 stopn  in  1  active-low stop/clear button, synchronous.
REQ-008 tick_1hz  in  1  one-cycle pulse, once per second.
REQ-009 sec_ones, sec_tens, min_ones, min_tens  out  4 each  BCD time digits, mm:ss.
REQ-010 enablen  out  1  drives the encoder enablen: low in IDLE/ENTRY, high in COUNTING/PAUSED.
REQ-011 counting  out  1  high only in COUNTING.
REQ-012 done  out  1  one-cycle pulse when the countdown reaches 00:00.

Function
REQ-013 States SHALL be IDLE, ENTRY, COUNTING and PAUSED; all outputs SHALL be registered.
REQ-014 Key accept SHALL occur once per press, after loadn is low with an unchanged BCD_IN for DEBOUNCE_CYCLES cycles; a BCD_IN change while low SHALL restart the count.
REQ-015 Re-arm SHALL require loadn high for at least 1 cycle; a held key SHALL produce exactly one accept.
REQ-016 An accepted BCD_IN > 9 SHALL be discarded with no state change.
REQ-017 Key accepts SHALL be acted on only in IDLE/ENTRY: shift min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit; state becomes ENTRY.
REQ-018 A fifth and later digit SHALL shift the oldest digit out (wrap-around entry).
REQ-019 A seconds field of 60-99 SHALL be accepted unchanged and counted down as entered.
REQ-020 startn and stopn SHALL act on their falling edge only (one action per press).
REQ-021 The start edge in ENTRY with a nonzero value SHALL move the block to COUNTING; a start in IDLE or with value 00:00 SHALL be ignored.
REQ-022 In COUNTING, each tick_1hz SHALL decrement by one second in BCD.
REQ-023 Decrement rule: sec_ones>0 decrements; otherwise sec_ones=9 with a borrow.
REQ-024 Borrow into sec_tens: sec_tens>0 decrements; otherwise sec_tens=5 with a borrow.
REQ-025 Borrow into minutes: min_ones decrements, or wraps 0->9 with min_tens decrementing.
REQ-026 The tick taking 00:01 to 00:00 SHALL move the block to IDLE and pulse done in that same registered cycle.
REQ-027 A stop edge SHALL act by state: COUNTING moves to PAUSED with digits held; PAUSED or ENTRY clears digits to 00:00 and moves to IDLE; IDLE does nothing.
REQ-028 The start edge in PAUSED SHALL resume COUNTING.
REQ-029 Key accepts in COUNTING/PAUSED SHALL be discarded.
REQ-030 Simultaneous events: stop beats start; stop beats tick (no decrement); start beats a key accept in the same cycle (key discarded); a tick outside COUNTING is ignored.

Reset
REQ-031 clearn low SHALL immediately force state IDLE, all digits 0, enablen=0, counting=0 and done=0, and clear the debounce counter and edge detectors, including mid-count or mid-debounce.
REQ-032 After clearn rises, the first key accept SHALL need a full DEBOUNCE_CYCLES period.

Structure
REQ-033 Shared package microwave_pkg SHALL hold the state encoding, BCD width (4) and DEBOUNCE_CYCLES default.
REQ-034 Debounce and one-shot accept logic SHALL be the sub-module key_debounce; the FSM and BCD arithmetic stay in keypad_timer.

Verification
REQ-035 Keys 1,3,0 each held low 6 cycles -> digits 01:30, state ENTRY, exactly 3 shifts.
REQ-036 Keys 1,2,3,4,5 -> 23:45; key 10'b-invalid BCD_IN=12 -> no change.
REQ-037 Enter 1:00, start, 2 ticks -> 00:58; stop then tick -> stays 00:58 PAUSED; start and 58 ticks -> 00:00, done pulses 1 cycle, IDLE.
REQ-038 loadn low 3 cycles with DEBOUNCE_CYCLES=4, or BCD_IN toggling while low -> no accept; held low 50 cycles -> one accept.
REQ-039 startn and stopn fall together in ENTRY -> clears to 00:00, IDLE; start at 00:00 -> ignored.
REQ-040 clearn pulsed mid-count at 05:17 -> outputs 00:00, enablen=0 asynchronously, and ticks are ignored afterwards.
